track_heading: RTL and testbench

Streaming colour-target tracker for the camera pipeline; consumes RGB444 pixels from the frame-buffer reader with a valid/ready handshake.
Per frame it accumulates column index and count of pixels matching a selectable colour channel. At frame end it computes the centroid column with a shared multi-cycle divider and converts it to a signed heading in degrees centred on the optical axis.
Feeds the servo/heading controller.

---
 rtl/track_heading_pkg.sv | 39 +++
 rtl/track_heading_if.sv | 14 +
 rtl/track_heading_seq_divider.sv | 101 ++++++++++
 rtl/track_heading.sv | 229 ++++++++++++++++++++++
 tb/tb_track_heading.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/track_heading_pkg.sv
// rtl/track_heading_pkg.sv - shared state encoding, channel codes and pixel match helper for track_heading
package track_pkg;

   typedef enum logic [1:0] {
      ACCUM     = 2'd0,
      DIV_COL   = 2'd1,
      DIV_SCALE = 2'd2,
      OUTPUT    = 2'd3
   } track_state_e;

   // chan_sel encoding; code 3 falls through to red
   localparam logic [1:0] CHAN_RED   = 2'd0;
   localparam logic [1:0] CHAN_GREEN = 2'd1;
   localparam logic [1:0] CHAN_BLUE  = 2'd2;

   // RGB444 field offsets inside the 12-bit pixel
   localparam int R_LSB = 8;
   localparam int G_LSB = 4;
   localparam int B_LSB = 0;

   // Target channel must exceed the margin and both other channels must sit
   // below target minus margin; the first term keeps the subtraction from wrapping.
   function automatic logic pixel_match(input logic [11:0] pix,
                                        input logic [1:0]  chan,
                                        input logic [3:0]  thr);
      logic [3:0] r, g, b, t, o1, o2, lim;
      r = pix[R_LSB +: 4];
      g = pix[G_LSB +: 4];
      b = pix[B_LSB +: 4];
      case (chan)
         CHAN_GREEN: begin t = g; o1 = r; o2 = b; end
         CHAN_BLUE:  begin t = b; o1 = r; o2 = g; end
         default:    begin t = r; o1 = g; o2 = b; end
      endcase
      lim = t - thr;
      return (t > thr) && (o1 < lim) && (o2 < lim);
   endfunction

endpackage

// File: rtl/track_heading_if.sv
// rtl/track_heading_if.sv - pixel stream valid/ready interface for track_heading
interface track_heading_if #(
   parameter int PIX_W = 12
);
   logic             pix_valid;
   logic             pix_ready;
   logic [PIX_W-1:0] pix_data;
   logic             pix_sof;

   // frame-buffer reader side
   modport master (output pix_valid, output pix_data, output pix_sof, input pix_ready);
   // tracker side
   modport slave (input pix_valid, input pix_data, input pix_sof, output pix_ready);
endinterface

// File: rtl/track_heading_seq_divider.sv
// rtl/track_heading_seq_divider.sv - restoring divider, one quotient bit per cycle, divide-by-zero yields 0
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             zero_q, zero_d;

   logic             load;
   logic [WIDTH-1:0] step_rem_in, step_dvd_in, step_dvs;
   logic [WIDTH-1:0] step_rem, step_dvd;
   logic [WIDTH:0]   trial;
   logic             qbit;

   // the load cycle already performs the first step, so a division takes WIDTH edges
   assign load = start && !busy_q;

   // one restoring step: shift next dividend bit into the remainder, subtract if it fits
   always_comb begin
      step_rem_in = load ? '0 : rem_q;
      step_dvd_in = load ? dividend : dvd_q;
      step_dvs    = load ? divisor : dvs_q;
      trial       = {step_rem_in, step_dvd_in[WIDTH-1]};
      if (trial >= {1'b0, step_dvs}) begin
         step_rem = trial[WIDTH-1:0] - step_dvs;
         qbit     = 1'b1;
      end else begin
         step_rem = trial[WIDTH-1:0];
         qbit     = 1'b0;
      end
      step_dvd = {step_dvd_in[WIDTH-2:0], qbit};
   end

   // sequencing: load, iterate WIDTH-1 more times, then pulse done
   always_comb begin
      rem_d  = rem_q;
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      zero_d = zero_q;
      if (load) begin
         rem_d  = step_rem;
         dvd_d  = step_dvd;
         dvs_d  = divisor;
         cnt_d  = CNT_W'(WIDTH - 1);
         busy_d = 1'b1;
         zero_d = (divisor == '0);
      end else if (busy_q) begin
         rem_d = step_rem;
         dvd_d = step_dvd;
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // divider state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         zero_q <= zero_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = zero_q ? '0 : dvd_q;

endmodule

// File: rtl/track_heading.sv
// rtl/track_heading.sv - colour-target centroid tracker producing a signed heading; optional TRACK_HEADING_SMOOTH_EN
module track_heading
   import track_pkg::*;
#(
   parameter int  IMAGE_WIDTH  = 320,
   parameter int  IMAGE_HEIGHT = 240,
   parameter int  FOV          = 25,
   parameter int  THRESHOLD    = 3,
   parameter int  MIN_PIXELS   = 16,
   parameter int  PIX_W        = 12,
   localparam int SUM_W        = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT * IMAGE_WIDTH),
   localparam int CNT_W        = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   track_heading_if.slave    pix,
   input  logic [1:0]        chan_sel,
   output logic signed [7:0] heading,
   output logic              detected,
   output logic              result_valid,
   output logic [CNT_W-1:0]  match_count
);
   localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
   localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [SUM_W-1:0] FOV_S    = SUM_W'(FOV);
   localparam logic [SUM_W-1:0] SPAN_S   = SUM_W'(IMAGE_WIDTH - 1);
   localparam logic [7:0]       HALF_FOV = 8'(FOV >> 1);
   localparam logic [3:0]       THR4     = 4'(THRESHOLD);
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);

   track_state_e     state_q, state_d;
   logic             ready_q, ready_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       chan_q, chan_d;
   logic             col_go_q, col_go_d;
   logic [7:0]       heading_q, heading_d;
   logic             detected_q, detected_d;
   logic             rv_q, rv_d;
   logic [CNT_W-1:0] mc_q, mc_d;
`ifdef TRACK_HEADING_SMOOTH_EN
   logic             prev_ok_q, prev_ok_d;
   logic [8:0]       avg9;
`endif

   logic [PIX_W-1:0] pix_word;
   logic             accept;
   logic [COL_W-1:0] base_col;
   logic [ROW_W-1:0] base_row;
   logic [SUM_W-1:0] base_sum;
   logic [CNT_W-1:0] base_cnt;
   logic [1:0]       eff_chan;
   logic             is_match;
   logic             last_pix;
   logic             det;
   logic [7:0]       raw_heading;

   logic             div_start, div_busy, div_done, scale_launch;
   logic [SUM_W-1:0] div_dividend, div_divisor, div_quo;

   assign pix_word = pix.pix_data;

   seq_divider #(.WIDTH(SUM_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   // shared divider: column average first, then the FOV scaling chained straight off its done
   always_comb begin
      scale_launch = (state_q == DIV_COL) && div_done;
      div_start    = (col_go_q && !div_busy) || scale_launch;
      div_dividend = scale_launch ? div_quo * FOV_S : sum_q;
      div_divisor  = scale_launch ? SPAN_S : SUM_W'(cnt_q);
   end

   // pixel-side view: sof restarts the frame before the pixel itself is accumulated
   always_comb begin
      accept   = pix.pix_valid && ready_q;
      base_col = pix.pix_sof ? '0 : col_q;
      base_row = pix.pix_sof ? '0 : row_q;
      base_sum = pix.pix_sof ? '0 : sum_q;
      base_cnt = pix.pix_sof ? '0 : cnt_q;
      eff_chan = pix.pix_sof ? chan_sel : chan_q;
      is_match = pixel_match(pix_word[11:0], eff_chan, THR4);
      last_pix = (base_col == LAST_COL) && (base_row == LAST_ROW);
   end

   // frame result from the scaled quotient; heading is zero unless the frame detected
   always_comb begin
      det         = (cnt_q >= MIN_CNT);
      raw_heading = div_quo[7:0] - HALF_FOV;
   end

   // main control: accumulate, two divide phases, one output cycle
   always_comb begin
      state_d    = state_q;
      ready_d    = ready_q;
      col_d      = col_q;
      row_d      = row_q;
      sum_d      = sum_q;
      cnt_d      = cnt_q;
      chan_d     = chan_q;
      col_go_d   = col_go_q;
      heading_d  = heading_q;
      detected_d = detected_q;
      rv_d       = 1'b0;
      mc_d       = mc_q;
`ifdef TRACK_HEADING_SMOOTH_EN
      prev_ok_d  = prev_ok_q;
      avg9       = '0;
`endif
      case (state_q)
         ACCUM: begin
            if (accept) begin
               chan_d = eff_chan;
               sum_d  = base_sum + (is_match ? SUM_W'(base_col) : '0);
               cnt_d  = base_cnt + CNT_W'(is_match);
               if (last_pix) begin
                  state_d  = DIV_COL;
                  ready_d  = 1'b0;
                  col_go_d = 1'b1;
                  col_d    = '0;
                  row_d    = '0;
               end else if (base_col == LAST_COL) begin
                  col_d = '0;
                  row_d = base_row + ROW_W'(1);
               end else begin
                  col_d = base_col + COL_W'(1);
                  row_d = base_row;
               end
            end
         end
         DIV_COL: begin
            col_go_d = col_go_q && !div_busy;
            if (div_done) begin
               state_d = DIV_SCALE;
            end
         end
         DIV_SCALE: begin
            if (div_done) begin
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            detected_d = det;
            mc_d       = cnt_q;
            rv_d       = 1'b1;
`ifdef TRACK_HEADING_SMOOTH_EN
            if (det) begin
               if (prev_ok_q) begin
                  avg9      = {heading_q[7], heading_q} + {raw_heading[7], raw_heading};
                  heading_d = avg9[8:1];
               end else begin
                  heading_d = raw_heading;
               end
               prev_ok_d = 1'b1;
            end else begin
               heading_d = '0;
               prev_ok_d = 1'b0;
            end
`else
            heading_d = det ? raw_heading : '0;
`endif
            state_d = ACCUM;
            ready_d = 1'b1;
            sum_d   = '0;
            cnt_d   = '0;
            col_d   = '0;
            row_d   = '0;
         end
         default: state_d = ACCUM;
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ACCUM;
         ready_q    <= 1'b1;
         col_q      <= '0;
         row_q      <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
         chan_q     <= CHAN_RED;
         col_go_q   <= 1'b0;
         heading_q  <= '0;
         detected_q <= 1'b0;
         rv_q       <= 1'b0;
         mc_q       <= '0;
`ifdef TRACK_HEADING_SMOOTH_EN
         prev_ok_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         col_q      <= col_d;
         row_q      <= row_d;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
         chan_q     <= chan_d;
         col_go_q   <= col_go_d;
         heading_q  <= heading_d;
         detected_q <= detected_d;
         rv_q       <= rv_d;
         mc_q       <= mc_d;
`ifdef TRACK_HEADING_SMOOTH_EN
         prev_ok_q  <= prev_ok_d;
`endif
      end
   end

   assign pix.pix_ready = ready_q;
   assign heading       = heading_q;
   assign detected      = detected_q;
   assign result_valid  = rv_q;
   assign match_count   = mc_q;

endmodule

// File: tb/tb_track_heading.sv
// tb/tb_track_heading.sv - directed self-checking bench for track_heading (8x4 image, FOV 28)
module tb_track_heading;
   localparam int W   = 8;
   localparam int H   = 4;
   localparam int NPX = W * H;
   localparam int LAT = 2 * 8 + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  chan_sel;
   logic signed [7:0] h1, h4;
   logic        det1, det4, rv1, rv4;
   logic [5:0]  mc1, mc4;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_acc = 0;
   int pulses = 0;
   int acc_cnt = 0;
   int mprev [2];
   bit mok [2];
   logic [11:0] fb [0:NPX-1];

   track_heading_if #(.PIX_W(12)) pif ();
   track_heading_if #(.PIX_W(12)) pif4 ();

   assign pif4.pix_valid = pif.pix_valid;
   assign pif4.pix_data  = pif.pix_data;
   assign pif4.pix_sof   = pif.pix_sof;

   track_heading #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FOV(28), .THRESHOLD(3),
                   .MIN_PIXELS(1), .PIX_W(12)) dut (
      .clk(clk), .rst(rst), .pix(pif), .chan_sel(chan_sel), .heading(h1),
      .detected(det1), .result_valid(rv1), .match_count(mc1));

   track_heading #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FOV(28), .THRESHOLD(3),
                   .MIN_PIXELS(4), .PIX_W(12)) dut4 (
      .clk(clk), .rst(rst), .pix(pif4), .chan_sel(chan_sel), .heading(h4),
      .detected(det4), .result_valid(rv4), .match_count(mc4));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rv1) pulses <= pulses + 1;
      if (pif.pix_valid && pif.pix_ready) acc_cnt <= acc_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // expected heading, including the running average when smoothing is built in
   task automatic model(input int inst, input int raw, input bit det, output int exp);
`ifdef TRACK_HEADING_SMOOTH_EN
      if (det) begin
         exp = mok[inst] ? ((mprev[inst] + raw) >>> 1) : raw;
         mok[inst] = 1'b1;
      end else begin
         exp = 0;
         mok[inst] = 1'b0;
      end
`else
      exp = det ? raw : 0;
`endif
      mprev[inst] = exp;
   endtask

   task automatic clear_fb(input logic [11:0] v);
      for (int i = 0; i < NPX; i++) fb[i] = v;
   endtask

   task automatic push(input logic [11:0] d, input bit s);
      int n;
      n = 0;
      pif.pix_data  = d;
      pif.pix_sof   = s;
      pif.pix_valid = 1'b1;
      @(negedge clk);
      while (!pif.pix_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("push_timeout", n, 0);
      @(posedge clk);
      #1;
      last_acc = cyc;
      pif.pix_valid = 1'b0;
      pif.pix_sof   = 1'b0;
   endtask

   task automatic send_frame();
      for (int i = 0; i < NPX; i++) push(fb[i], i == 0);
   endtask

   task automatic wait_check(input string tag, input int raw, input int mc);
      bit got;
      int lat, e1, e4;
      got = 1'b0;
      lat = -1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (rv1) begin
            got = 1'b1;
            lat = cyc - last_acc;
         end
      end
      pif.pix_valid = 1'b0;
      model(0, raw, mc >= 1, e1);
      model(1, raw, mc >= 4, e4);
      check({tag, "_rv"}, got, 1);
      check({tag, "_lat"}, lat, LAT);
      check({tag, "_h"}, h1, e1);
      check({tag, "_det"}, det1, mc >= 1);
      check({tag, "_mc"}, mc1, mc);
      check({tag, "_rv4"}, rv4, 1);
      check({tag, "_h4"}, h4, e4);
      check({tag, "_det4"}, det4, mc >= 4);
      check({tag, "_mc4"}, mc4, mc);
      @(negedge clk);
      check({tag, "_pulse"}, rv1, 0);
   endtask

   task automatic run_frame(input string tag, input int raw, input int mc);
      send_frame();
      wait_check(tag, raw, mc);
   endtask

   initial begin
      int p0, a0;
      rst = 1'b1;
      chan_sel = 2'd0;
      pif.pix_valid = 1'b0;
      pif.pix_data  = '0;
      pif.pix_sof   = 1'b0;
      mok[0] = 0; mok[1] = 0; mprev[0] = 0; mprev[1] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", pif.pix_ready, 1);
      check("rst_heading", h1, 0);
      check("rst_det", det1, 0);
      check("rst_rv", rv1, 0);
      check("rst_mc", mc1, 0);

      // single red pixel at col 7
      clear_fb(12'h000); fb[7] = 12'hF00;
      run_frame("col7", 14, 1);
      // cols 3 and 4: avg 3, q 12
      clear_fb(12'h000); fb[3] = 12'hF00; fb[4] = 12'hF00;
      run_frame("col34", -2, 2);
      // col 0 on the last row
      clear_fb(12'h000); fb[24] = 12'hF00;
      run_frame("col0", -14, 1);
      // green target among red pixels
      chan_sel = 2'd1;
      clear_fb(12'hF00); fb[15] = 12'h0F0;
      run_frame("green", 14, 1);
      // threshold edge: 3F3 matches green, CFC does not
      clear_fb(12'h000); fb[2] = 12'h3F3; fb[6] = 12'hCFC;
      run_frame("thresh", -6, 1);
      // blue target
      chan_sel = 2'd2;
      clear_fb(12'h000); fb[31] = 12'h00F; fb[0] = 12'hF00;
      run_frame("blue", 14, 1);
      // code 3 selects red
      chan_sel = 2'd3;
      clear_fb(12'h000); fb[0] = 12'h00F; fb[15] = 12'hF00;
      run_frame("chan3", 14, 1);
      chan_sel = 2'd0;
      // three matches at col 5
      clear_fb(12'h000); fb[5] = 12'hF00; fb[13] = 12'hF00; fb[21] = 12'hF00;
      run_frame("three", 6, 3);
      // no matches
      clear_fb(12'h000);
      run_frame("none", 0, 0);
      // exactly four matches at cols 1,2,3,6
      clear_fb(12'h000); fb[1] = 12'hF00; fb[10] = 12'hF00; fb[19] = 12'hF00; fb[30] = 12'hF00;
      run_frame("four", -2, 4);

      // mid-frame sof: 10 red pixels then a fresh frame; valid held through compute
      p0 = pulses;
      push(12'hF00, 1'b1);
      for (int i = 1; i < 10; i++) push(12'hF00, 1'b0);
      clear_fb(12'h000); fb[7] = 12'hF00;
      send_frame();
      pif.pix_data  = 12'hF00;
      pif.pix_valid = 1'b1;
      a0 = acc_cnt;
      wait_check("resync", 14, 1);
      check("hold_no_accept", acc_cnt - a0, 0);
      repeat (25) @(negedge clk);
      check("resync_one_result", pulses - p0, 1);

      // reset during the scaling divide
      clear_fb(12'h000); fb[7] = 12'hF00;
      send_frame();
      repeat (12) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_heading", h1, 0);
      check("mid_rst_det", det1, 0);
      check("mid_rst_mc", mc1, 0);
      check("mid_rst_rv", rv1, 0);
      @(negedge clk);
      rst = 1'b0;
      mok[0] = 0; mok[1] = 0; mprev[0] = 0; mprev[1] = 0;
      p0 = pulses;
      @(negedge clk);
      check("post_rst_ready", pif.pix_ready, 1);
      repeat (30) @(negedge clk);
      check("post_rst_no_result", pulses - p0, 0);

      // +14 then -14
      clear_fb(12'h000); fb[7] = 12'hF00;
      run_frame("seq_pos", 14, 1);
      clear_fb(12'h000); fb[8] = 12'hF00;
      run_frame("seq_neg", -14, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
